// File: rtl/mstream_pkg.sv
// Shared constants and state encoding for the MSTREAM receive/capture path.
package mstream_pkg;

  localparam int unsigned MSTREAM_PINS   = 16;
  localparam int unsigned MSTREAM_WORD   = 32;
  localparam int unsigned PATTERN_LINE   = 256;
  localparam int unsigned BEATS_PER_LINE = 8;
  localparam int unsigned LINE_CNT_W     = 32;
  localparam int unsigned DROP_CNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } cap_state_e;

endpackage

// File: rtl/mstream_line_packer.sv
// Collects stream words into one pattern line, first word in the most significant slot.
module mstream_line_packer
  import mstream_pkg::*;
#(
  parameter int unsigned DW_IN = MSTREAM_WORD,
  parameter int unsigned BEATS = BEATS_PER_LINE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     beat_en,
  input  logic [DW_IN-1:0]         din,
  output logic                     line_done_c,
  output logic [DW_IN*BEATS-1:0]   line_c
);

  localparam int unsigned IDX_W   = $clog2(BEATS);
  localparam int unsigned LINE_W  = DW_IN * BEATS;
  localparam int unsigned SHIFT_W = LINE_W - DW_IN;

  logic [IDX_W-1:0]   beat_idx_q, beat_idx_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;

  // The current word is always the lowest slot, so earlier beats end up higher.
  assign line_c      = {shift_q, din};
  assign line_done_c = beat_en && (beat_idx_q == IDX_W'(BEATS - 1));

  always_comb begin
    beat_idx_d = beat_idx_q;
    shift_d    = shift_q;
    if (clear) begin
      beat_idx_d = '0;
    end else if (beat_en) begin
      beat_idx_d = line_done_c ? '0 : beat_idx_q + IDX_W'(1);
      shift_d    = line_c[SHIFT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_idx_q <= '0;
      shift_q    <= '0;
    end else begin
      beat_idx_q <= beat_idx_d;
      shift_q    <= shift_d;
    end
  end

endmodule

// File: rtl/mstream_capture.sv
// Armed MSTREAM capture: packs 32-bit words into 256-bit lines, hands them to a
// valid/ready host FIFO, and counts captured and dropped lines.
module mstream_capture
  import mstream_pkg::*;
#(
  parameter int unsigned DW_IN  = MSTREAM_WORD,
  parameter int unsigned DW_OUT = PATTERN_LINE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic [LINE_CNT_W-1:0] num_lines,
  input  logic [DW_IN-1:0]      din,
  input  logic                  din_en,
  output logic [DW_OUT-1:0]     dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [LINE_CNT_W-1:0] lines_captured,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int unsigned BEATS = DW_OUT / DW_IN;

  cap_state_e            state_q, state_d;
  logic [LINE_CNT_W-1:0] num_lines_q, num_lines_d;
  logic [LINE_CNT_W-1:0] lines_q, lines_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic [DW_OUT-1:0]     dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  overflow_q, overflow_d;

  logic                  arm_ok_c;
  logic                  beat_en_c;
  logic                  line_done_c;
  logic [DW_OUT-1:0]     line_c;

  assign arm_ok_c  = arm && (state_q != CAPTURE);
  assign beat_en_c = din_en && (state_q == CAPTURE);

  mstream_line_packer #(
    .DW_IN (DW_IN),
    .BEATS (BEATS)
  ) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (arm_ok_c),
    .beat_en     (beat_en_c),
    .din         (din),
    .line_done_c (line_done_c),
    .line_c      (line_c)
  );

  always_comb begin
    state_d      = state_q;
    num_lines_d  = num_lines_q;
    lines_d      = lines_q;
    drop_d       = drop_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    done_d       = done_q;
    overflow_d   = overflow_q;

    // Holding register drains regardless of capture state.
    if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (arm_ok_c) begin
          num_lines_d = num_lines;
          lines_d     = '0;
          drop_d      = '0;
          overflow_d  = 1'b0;
          if (num_lines == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = CAPTURE;
            done_d  = 1'b0;
          end
        end
      end
      CAPTURE: begin
        if (line_done_c) begin
          lines_d = lines_q + LINE_CNT_W'(1);
          if (!dout_valid_q || dout_ready) begin
            dout_d       = line_c;
            dout_valid_d = 1'b1;
          end else begin
            overflow_d = 1'b1;
            if (drop_q != '1) begin
              drop_d = drop_q + DROP_CNT_W'(1);
            end
          end
          if (lines_d == num_lines_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CAPTURE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      num_lines_q  <= '0;
      lines_q      <= '0;
      drop_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_lines_q  <= num_lines_d;
      lines_q      <= lines_d;
      drop_q       <= drop_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign dout           = dout_q;
  assign dout_valid     = dout_valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign overflow       = overflow_q;
  assign lines_captured = lines_q;
  assign drop_cnt       = drop_q;

endmodule

// File: tb/tb_mstream_capture.sv
// Directed bench for mstream_capture: expected lines are queued as beats are
// driven and checked against every dout transfer.
module tb_mstream_capture;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         arm;
  logic [31:0]  num_lines;
  logic [31:0]  din;
  logic         din_en;
  logic [255:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         busy;
  logic         done;
  logic         overflow;
  logic [31:0]  lines_captured;
  logic [15:0]  drop_cnt;

  int total = 0;
  int bad   = 0;
  logic [255:0] exp_q[$];

  always #5 clk = ~clk;

  mstream_capture dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .arm            (arm),
    .num_lines      (num_lines),
    .din            (din),
    .din_en         (din_en),
    .dout           (dout),
    .dout_valid     (dout_valid),
    .dout_ready     (dout_ready),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow),
    .lines_captured (lines_captured),
    .drop_cnt       (drop_cnt)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [255:0] mkline(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[255-32*k -: 32] = base + 32'(k);
    return l;
  endfunction

  // Every transfer seen before the rising edge must match the oldest queued line.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_line observed=%0h expected=none", dout);
      end else begin
        chk("line_data", dout, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [31:0] n);
    arm       = 1'b1;
    num_lines = n;
    tick();
    arm       = 1'b0;
  endtask

  task automatic beat(input logic [31:0] w);
    din_en = 1'b1;
    din    = w;
    tick();
    din_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; num_lines = '0; din = '0; din_en = 1'b0; dout_ready = 1'b0;
    tick(); tick();
    chk("rst_dout",      dout,           '0);
    chk("rst_valid",     dout_valid,     '0);
    chk("rst_busy",      busy,           '0);
    chk("rst_done",      done,           '0);
    chk("rst_overflow",  overflow,       '0);
    chk("rst_lines",     lines_captured, '0);
    chk("rst_drop",      drop_cnt,       '0);
    rst_n = 1'b1;
    tick();

    // Two lines, always ready
    dout_ready = 1'b1;
    do_arm(2);
    chk("t1_busy_after_arm", busy, 1);
    exp_q.push_back(mkline(32'h0));
    exp_q.push_back(mkline(32'h8));
    for (int i = 0; i < 16; i++) begin
      beat(32'(i));
      if (i == 7) begin
        chk("t1_latency_valid", dout_valid, 1);
        chk("t1_latency_line",  dout,       mkline(32'h0));
        chk("t1_lines_mid",     lines_captured, 1);
      end
    end
    chk("t1_busy",  busy,           0);
    chk("t1_done",  done,           1);
    chk("t1_lines", lines_captured, 2);
    tick(); tick();
    chk("t1_drained", 256'(exp_q.size()), 0);

    // Back-pressure: line 0 held, lines 1 and 2 dropped
    dout_ready = 1'b0;
    do_arm(3);
    chk("t2_done_cleared", done, 0);
    exp_q.push_back(mkline(32'h100));
    for (int i = 0; i < 24; i++) beat(32'h100 + 32'(i));
    chk("t2_drop",     drop_cnt,       2);
    chk("t2_overflow", overflow,       1);
    chk("t2_lines",    lines_captured, 3);
    chk("t2_done",     done,           1);
    chk("t2_held",     dout,           mkline(32'h100));
    dout_ready = 1'b1;
    tick();
    chk("t2_valid_cleared", dout_valid, 0);
    chk("t2_drained", 256'(exp_q.size()), 0);

    // Ready asserted exactly on the cycle line 1 completes
    dout_ready = 1'b0;
    do_arm(2);
    chk("t3_counters_cleared", {overflow, drop_cnt, lines_captured}, '0);
    exp_q.push_back(mkline(32'h200));
    exp_q.push_back(mkline(32'h208));
    for (int i = 0; i < 15; i++) beat(32'h200 + 32'(i));
    dout_ready = 1'b1;
    beat(32'h20F);
    chk("t3_valid",    dout_valid, 1);
    chk("t3_line1",    dout,       mkline(32'h208));
    chk("t3_drop",     drop_cnt,   0);
    chk("t3_overflow", overflow,   0);
    tick();
    chk("t3_valid_cleared", dout_valid, 0);
    chk("t3_drained", 256'(exp_q.size()), 0);

    // Zero-line arm
    do_arm(0);
    chk("t4_done",  done,       1);
    chk("t4_busy",  busy,       0);
    chk("t4_valid", dout_valid, 0);
    for (int i = 0; i < 9; i++) beat(32'hDEAD0000 + 32'(i));
    chk("t4_lines", lines_captured, 0);
    chk("t4_valid_after", dout_valid, 0);

    // Reset mid-line with a pending line held
    dout_ready = 1'b0;
    do_arm(2);
    exp_q.push_back(mkline(32'h300));
    for (int i = 0; i < 13; i++) beat(32'h300 + 32'(i));
    chk("t5_pending", dout_valid, 1);
    rst_n = 1'b0;
    exp_q.delete();
    #2;
    chk("t5_rst_valid", dout_valid,     0);
    chk("t5_rst_dout",  dout,           '0);
    chk("t5_rst_busy",  busy,           0);
    chk("t5_rst_lines", lines_captured, 0);
    tick();
    rst_n = 1'b1;
    dout_ready = 1'b1;
    do_arm(1);
    exp_q.push_back(mkline(32'h400));
    for (int i = 0; i < 8; i++) beat(32'h400 + 32'(i));
    chk("t5_line_after", dout, mkline(32'h400));
    chk("t5_done",  done,           1);
    chk("t5_lines", lines_captured, 1);
    tick();
    chk("t5_drained", 256'(exp_q.size()), 0);

    // din_en in IDLE, then arm while busy
    do_reset();
    for (int i = 0; i < 4; i++) beat(32'h600 + 32'(i));
    chk("t6_idle_busy",  busy,           0);
    chk("t6_idle_lines", lines_captured, 0);
    chk("t6_idle_valid", dout_valid,     0);
    do_arm(1);
    exp_q.push_back(mkline(32'h500));
    for (int i = 0; i < 3; i++) beat(32'h500 + 32'(i));
    do_arm(5);
    chk("t6_still_busy", busy, 1);
    for (int i = 3; i < 8; i++) beat(32'h500 + 32'(i));
    chk("t6_line",  dout,           mkline(32'h500));
    chk("t6_done",  done,           1);
    chk("t6_lines", lines_captured, 1);
    tick(); tick();
    chk("final_drained", 256'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mstream_capture.md
# mstream_capture

Receive-side counterpart of the pattern streaming path. It samples the 32-bit recombined MSTREAM word (16 rising-edge bits plus 16 falling-edge bits) under the stream enable and repacks eight words into one 256-bit pattern line. Each line is handed to a 256-bit host-bound FIFO with a valid/ready handshake, and the block counts lines per armed capture. It is used for pattern loopback and readback checking, and sits between the sensor-side capture registers and the host readout FIFO.

## Interface
- DW_IN, 32, input word width (16 DDR pins × 2 edges)
- DW_OUT, 256, output line width; must be DW_IN × 8
- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous, active-low reset
- arm  in  1  single-cycle pulse; starts a capture
- num_lines  in  32  lines to capture; latched on arm
- din  in  32  stream word; [15:0] = rising-edge bits, [31:16] = falling-edge bits
- din_en  in  1  din is valid this cycle
- dout  out  256  packed line
- dout_valid  out  1  dout holds an undelivered line
- dout_ready  in  1  downstream can accept (driven as !full)
- busy  out  1  high in CAPTURE
- done  out  1  sticky; capture complete
- overflow  out  1  sticky; at least one line dropped
- lines_captured  out  32  completed lines in this capture, dropped lines included
- drop_cnt  out  16  dropped lines, saturating at 0xFFFF

## Operation
- States:
  - IDLE → CAPTURE on arm with num_lines ≠ 0.
  - IDLE → DONE on arm with num_lines = 0.
  - CAPTURE → DONE when lines_captured reaches the latched num_lines.
  - DONE → CAPTURE (or DONE) on the next arm.
- arm while busy is ignored.
- An accepted arm clears beat_idx, lines_captured, drop_cnt, overflow and done. It does not disturb a pending dout line.
- Packing:
  - 3-bit beat_idx counts din_en beats in CAPTURE only.
  - Beat k is written to bits [255−32k −: 32], so the first word lands in [255:224]. This matches the MSB-first read order of the 256→32 transmit FIFO, and loopback reproduces the original 256-bit line bit-exactly.
- Line complete: beat_idx = 7 with din_en.
  - If the holding register is empty, or is being accepted (dout_valid && dout_ready) in the same cycle, the assembled line is loaded into dout and dout_valid is set.
  - Otherwise the line is dropped: overflow is set and drop_cnt increments (saturating).
- lines_captured increments on every line complete, including dropped lines.
- din_en outside CAPTURE is ignored and beat_idx holds.
- A partial line at the transition to DONE cannot occur: the transition happens only on a line boundary.
- dout_valid clears on dout_ready unless a new line loads in the same cycle.
- dout and dout_valid are independent of state. A pending line is always delivered, including in IDLE and DONE.

## Timing
- Reset values: dout = 0, dout_valid = 0, busy = 0, done = 0, overflow = 0, lines_captured = 0, drop_cnt = 0, state = IDLE, beat_idx = 0.
- Asynchronous assert, synchronous deassert. The reset synchronizer lives outside this block.
- arm at cycle n: busy = 1 at n+1. din_en is honoured from n+1.
- 8th beat at cycle m:
  - dout_valid = 1 and dout updated at m+1.
  - lines_captured updated at m+1.
- Final line at cycle m: busy = 0 and done = 1 at m+1.
- Sustained throughput: one line per 8 cycles.
- Handshake: a transfer occurs on the rising edge where dout_valid && dout_ready. dout is stable while dout_valid && !dout_ready.
- Simultaneous line complete and accept: no drop; the new line is visible at the next cycle.
- rst_n low mid-line discards the partial line and any pending dout.

## Structure
- Shared package `mstream_pkg`:
  - Constants MSTREAM_PINS = 16, MSTREAM_WORD = 32, PATTERN_LINE = 256, BEATS_PER_LINE = 8.
  - State enum IDLE / CAPTURE / DONE.
- One sub-module, `mstream_line_packer`: beat_idx plus the 256-bit shift/assemble register, emitting line_done and the assembled line.
- The top level holds the FSM, holding register, counters and handshake.

## Test plan
- Reset, then arm with num_lines = 2; drive 16 beats with din = 0x00000000…0x0000000F and dout_ready = 1:
  - Line 0 = {0x0,0x1,…,0x7} MSB-first, at cycle 9 after the first beat.
  - Line 1 = {0x8,…,0xF}.
  - done = 1 and busy = 0 after the 16th beat; lines_captured = 2.
- Arm with num_lines = 3 and dout_ready held 0; drive 24 beats:
  - Line 0 is held.
  - Lines 1 and 2 are dropped: drop_cnt = 2, overflow = 1, lines_captured = 3, done = 1.
  - Raising dout_ready delivers line 0 unchanged.
- Assert dout_ready on exactly the cycle the 2nd line completes: no drop, and line 1 is presented on the next cycle.
- Arm with num_lines = 0: done = 1 at the next cycle, no dout_valid; din_en beats are ignored.
- Pulse rst_n low after 5 beats of a line: all outputs return to reset values; after re-arm, the next 8 beats form a clean line 0.
- Pulse arm while busy, and toggle din_en in IDLE: both are ignored, and the counters and line content are unchanged.
